// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - state encoding, requester ids and latency limits for mem_arbiter
package mem_arb_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic ID_CPU = 1'b0;
  localparam logic ID_DBG = 1'b1;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;
  localparam int CNT_W   = 4;

  // Clamp the latency parameter into the counter's legal range.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    if (lat < LAT_MIN) return CNT_W'(LAT_MIN);
    if (lat > LAT_MAX) return CNT_W'(LAT_MAX);
    return CNT_W'(lat);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way winner pick with last-grant pointer
// MEM_ARB_CPU_PRIORITY_EN: cpu wins every tie instead of alternating.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_cpu,
  input  logic req_dbg,
  input  logic take,
  output logic any_req,
  output logic win_id
);

  logic last_q, last_d;

  always_comb begin
    any_req = req_cpu | req_dbg;
    if (req_cpu && req_dbg) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      win_id = ID_CPU;
`else
      win_id = (last_q == ID_CPU) ? ID_DBG : ID_CPU;
`endif
    end else begin
      win_id = req_cpu ? ID_CPU : ID_DBG;
    end
    last_d = (take && any_req) ? win_id : last_q;
  end

  // Pointer resets to dbg so the first tie after reset goes to cpu.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= ID_DBG;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - cpu/dbg arbiter in front of a single-port fixed-latency memory
// MEM_ARB_CPU_PRIORITY_EN selects fixed cpu priority in rr_arb2.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_ready,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          gnt_id
);

  localparam logic [CNT_W-1:0] LAT_CNT = lat_to_cnt(LAT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]    dbg_rdata_q, dbg_rdata_d;
  logic             any_req, win_id, take;

  assign take = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_cpu (cpu_req),
    .req_dbg (dbg_req),
    .take    (take),
    .any_req (any_req),
    .win_id  (win_id)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dbg_rdata_d = dbg_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ISSUE;
          id_d    = win_id;
          we_d    = (win_id == ID_DBG) ? dbg_we    : cpu_we;
          addr_d  = (win_id == ID_DBG) ? dbg_addr  : cpu_addr;
          wdata_d = (win_id == ID_DBG) ? dbg_wdata : cpu_wdata;
        end
      end
      ST_ISSUE: begin
        cnt_d   = LAT_CNT;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Last wait cycle is exactly LAT cycles after mem_en: read data is valid now.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_RESP;
          if (!we_q) begin
            if (id_q == ID_DBG) dbg_rdata_d = mem_rdata;
            else                cpu_rdata_d = mem_rdata;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      id_q        <= ID_CPU;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

  assign mem_en    = (state_q == ST_ISSUE);
  assign mem_we    = (state_q == ST_ISSUE) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign gnt_id    = id_q;
  assign cpu_ready = (state_q == ST_RESP) && (id_q == ID_CPU);
  assign dbg_ready = (state_q == ST_RESP) && (id_q == ID_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a transaction-level reference model
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ready;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_ready;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          gnt_id;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata), .dbg_ready(dbg_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .gnt_id(gnt_id)
  );

  typedef struct { logic id; logic we; logic [31:0] addr; logic [31:0] wdata; int cyc; } mem_exp_t;
  typedef struct { logic id; int cyc; logic [31:0] cpu_rd; logic [31:0] dbg_rd; } rsp_exp_t;

  mem_exp_t    mem_q[$];
  rsp_exp_t    rsp_q[$];
  logic        gnt_log[$];
  logic [31:0] shadow [bit [31:0]];
  logic [31:0] store  [bit [31:0]];
  logic [31:0] pipe   [0:LAT];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int          next_free = 0;
  logic        last_id = 1'b1;
  logic [31:0] m_cpu_rd = '0, m_dbg_rd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one access at a time, occupying LAT+3 cycles from the sampling cycle.
  task automatic model_step();
    mem_exp_t    me;
    rsp_exp_t    re;
    logic        w;
    logic [31:0] rd;
    if (cyc < next_free || !(cpu_req || dbg_req)) return;
    if (cpu_req && dbg_req) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      w = 1'b0;
`else
      w = ~last_id;
`endif
    end else begin
      w = dbg_req;
    end
    last_id  = w;
    me.id    = w;
    me.we    = w ? dbg_we    : cpu_we;
    me.addr  = w ? dbg_addr  : cpu_addr;
    me.wdata = w ? dbg_wdata : cpu_wdata;
    me.cyc   = cyc + 1;
    if (me.we) begin
      shadow[me.addr] = me.wdata;
    end else begin
      rd = shadow.exists(me.addr) ? shadow[me.addr] : dflt(me.addr);
      if (w) m_dbg_rd = rd;
      else   m_cpu_rd = rd;
    end
    re.id     = w;
    re.cyc    = cyc + LAT + 2;
    re.cpu_rd = m_cpu_rd;
    re.dbg_rd = m_dbg_rd;
    mem_q.push_back(me);
    rsp_q.push_back(re);
    next_free = cyc + LAT + 3;
  endtask

  // Memory responder: read data appears exactly LAT cycles after the mem_en cycle, noise otherwise.
  always @(negedge clk) begin
    for (int i = LAT; i > 0; i--) pipe[i] = pipe[i-1];
    if (mem_en && !mem_we) pipe[0] = store.exists(mem_addr) ? store[mem_addr] : dflt(mem_addr);
    else                   pipe[0] = $urandom;
    if (mem_en && mem_we) store[mem_addr] = mem_wdata;
    mem_rdata = pipe[LAT];
  end

  always @(negedge clk) begin : monitor
    mem_exp_t me;
    rsp_exp_t re;
    if (!reset) begin
      if (mem_we && !mem_en) chk("mem_we_without_en", 32'(mem_we), 32'd0);
      if (mem_en) begin
        gnt_log.push_back(gnt_id);
        chk("mem_en_expected", 32'(mem_q.size() != 0), 32'd1);
        if (mem_q.size() != 0) begin
          me = mem_q.pop_front();
          chk("mem_en_cycle", cyc, me.cyc);
          chk("gnt_id", 32'(gnt_id), 32'(me.id));
          chk("mem_we", 32'(mem_we), 32'(me.we));
          chk("mem_addr", mem_addr, me.addr);
          if (me.we) chk("mem_wdata", mem_wdata, me.wdata);
        end
      end
      if (cpu_ready || dbg_ready) begin
        chk("ready_onehot", 32'(cpu_ready & dbg_ready), 32'd0);
        chk("ready_expected", 32'(rsp_q.size() != 0), 32'd1);
        if (rsp_q.size() != 0) begin
          re = rsp_q.pop_front();
          chk("ready_cycle", cyc, re.cyc);
          chk("ready_port", 32'(dbg_ready), 32'(re.id));
          chk("cpu_rdata", cpu_rdata, re.cpu_rd);
          chk("dbg_rdata", dbg_rdata, re.dbg_rd);
        end
      end
      if (mem_q.size() != 0 && mem_q[0].cyc <= cyc) begin
        chk("mem_en_missing", cyc, mem_q[0].cyc);
        void'(mem_q.pop_front());
      end
      if (rsp_q.size() != 0 && rsp_q[0].cyc <= cyc) begin
        chk("ready_missing", cyc, rsp_q[0].cyc);
        void'(rsp_q.pop_front());
      end
    end
  end

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_req = r; cpu_we = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dbg(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    dbg_req = r; dbg_we = w; dbg_addr = a; dbg_wdata = d;
  endtask

  task automatic drain();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    for (int i = 0; i < 60 && (mem_q.size() != 0 || rsp_q.size() != 0); i++) step();
    step();
    chk("drain_empty", 32'(mem_q.size() + rsp_q.size()), 32'd0);
  endtask

  // Called at #1 after a rising edge; reset takes effect at once.
  task automatic apply_reset();
    reset = 1'b1;
    #1;
    chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst_dbg_ready", 32'(dbg_ready), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_gnt_id", 32'(gnt_id), 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_dbg_rdata", dbg_rdata, 32'd0);
    rsp_q.delete();
    mem_q.delete();
    repeat (2) @(posedge clk);
    #1;
    next_free = 0;
    last_id   = 1'b1;
    m_cpu_rd  = '0;
    m_dbg_rd  = '0;
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] dbg_before;
    logic        exp_g;
    store[32'h40]  = 32'hDEADBEEF;
    shadow[32'h40] = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    apply_reset();

    // Single cpu read
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    step();
    cpu_req = 1'b0;
    drain();
    chk("read_40_cpu_rdata", cpu_rdata, 32'hDEADBEEF);

    // Simultaneous requests held through ready, starting from reset
    @(posedge clk);
    #1;
    apply_reset();
    gnt_log.delete();
    set_cpu(1'b1, 1'b0, 32'h44, 32'h0);
    set_dbg(1'b1, 1'b0, 32'h48, 32'h0);
    for (int i = 0; i < 4 * (LAT + 3); i++) step();
    drain();
    chk("tie_count", 32'(gnt_log.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef MEM_ARB_CPU_PRIORITY_EN
      exp_g = 1'b0;
`else
      exp_g = i[0];
`endif
      chk("tie_grant", 32'(gnt_log[i]), 32'(exp_g));
    end

    // Debug write leaves dbg_rdata untouched
    dbg_before = dbg_rdata;
    gnt_log.delete();
    set_dbg(1'b1, 1'b1, 32'h10, 32'h12345678);
    step();
    dbg_req = 1'b0;
    drain();
    chk("wr_single_mem_en", 32'(gnt_log.size()), 32'd1);
    chk("wr_dbg_rdata_kept", dbg_rdata, dbg_before);
    chk("wr_mem_stored", store[32'h10], 32'h12345678);

    // Request dropped and address changed while waiting
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    step();
    step();
    set_cpu(1'b0, 1'b0, 32'h80, 32'h0);
    drain();

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      set_cpu($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 31)) << 2, $urandom);
      set_dbg($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 31)) << 2, $urandom);
      step();
    end
    drain();

    // Reset during WAIT aborts the access; next tie goes to cpu
    set_cpu(1'b1, 1'b0, 32'h40, 32'h0);
    set_dbg(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    cpu_req = 1'b0;
    step();
    step();
    chk("abort_mem_issued", 32'(mem_q.size()), 32'd0);
    apply_reset();
    gnt_log.delete();
    set_cpu(1'b1, 1'b0, 32'h44, 32'h0);
    set_dbg(1'b1, 1'b0, 32'h48, 32'h0);
    step();
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    drain();
    chk("post_reset_tie_count", 32'(gnt_log.size()), 32'd1);
    if (gnt_log.size() != 0) chk("post_reset_tie_cpu", 32'(gnt_log[0]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
